// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// ----------------
// Multicycle MULT/DIV engine for the multicycle MIPS core. The control FSM
// pulses start_mult or start_div for one cycle and then waits on busy/done.
// The engine retires one bit per cycle and owns the HI/LO registers.
//
// Multiply: radix-2 Booth, WIDTH steps, 2*WIDTH+1 bit accumulator shifted
//           arithmetically right one place per step.
// Divide:   restoring division on operand magnitudes, WIDTH steps, with the
//           sign fix-up folded into the final step (quotient truncates toward
//           zero, remainder follows the dividend's sign).
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high; aborts any operation, clears HI/LO
//   start_mult   pulse: begin multiply op_a * op_b (wins over start_div)
//   start_div    pulse: begin divide op_a / op_b
//   op_a, op_b   operands, sampled on the edge that accepts a start
//   is_unsigned  (only with MULDIV_UNSIGNED_EN) treat operands as unsigned
//   busy         high while iterating (MULT or DIV state)
//   done         one-cycle pulse when the operation finishes
//   div_zero     one-cycle pulse with done when the divisor was zero
//   hi_lo_write  one-cycle pulse with done when HI/LO were updated
//   hi_out       HI register (product upper half / remainder)
//   lo_out       LO register (product lower half / quotient)
//
// Configuration:
//   MULDIV_UNSIGNED_EN  when defined, adds the is_unsigned input so the core
//                       can issue MULTU/DIVU. When undefined, every operation
//                       is signed.

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_lo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FINISH
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count, count_next;
  logic             busy_next, done_next, div_zero_next, hi_lo_write_next;
  logic [WIDTH-1:0] hi_next, lo_next;

  logic uns_in;
  logic uns_r;
  logic a_sign_r;
  logic b_sign_r;

  // Booth datapath: accumulator holds {A[WIDTH:0], Q[WIDTH-1:0]}, with the
  // extra Booth bit q(-1) kept alongside.
  logic [2*WIDTH:0]   booth_acc;
  logic               booth_qm1;
  logic [WIDTH:0]     booth_mcand;
  logic [WIDTH:0]     booth_a;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   booth_next;
  logic [2*WIDTH-1:0] booth_fix;
  logic [2*WIDTH-1:0] product;

  // Restoring-division datapath on magnitudes.
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_dvs;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             accept_mult;
  logic             accept_div;
  logic             last_iter;

`ifdef MULDIV_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign accept_mult = (state == IDLE) && start_mult;
  assign accept_div  = (state == IDLE) && start_div && !start_mult && (op_b != '0);
  assign last_iter   = (count == CW'(WIDTH - 1));

  assign mag_a = (!uns_in && op_a[WIDTH-1]) ? (-op_a) : op_a;
  assign mag_b = (!uns_in && op_b[WIDTH-1]) ? (-op_b) : op_b;

  // One Booth step. For an unsigned multiply the W steps treat the multiplier
  // as signed, so its MSB weight is restored by adding the multiplicand at
  // bit position WIDTH (the zero-extended multiplier's extra Booth step).
  always_comb begin
    booth_a = booth_acc[2*WIDTH:WIDTH];
    case ({booth_acc[0], booth_qm1})
      2'b01:   booth_sum = booth_a + booth_mcand;
      2'b10:   booth_sum = booth_a - booth_mcand;
      default: booth_sum = booth_a;
    endcase
    booth_next = {booth_sum[WIDTH], booth_sum, booth_acc[WIDTH-1:1]};
    booth_fix  = (uns_r && b_sign_r) ? {booth_mcand[WIDTH-1:0], {WIDTH{1'b0}}} : '0;
    product    = booth_next[2*WIDTH-1:0] + booth_fix;
  end

  // One restoring-division step. The partial remainder is always below the
  // divisor, so WIDTH bits hold it; only the shifted value needs one more.
  always_comb begin
    div_shift = {div_rem, div_quo[WIDTH-1]};
    if (div_shift >= {1'b0, div_dvs}) begin
      div_rem_next = div_shift[WIDTH-1:0] - div_dvs;
      div_quo_next = {div_quo[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_next = div_shift[WIDTH-1:0];
      div_quo_next = {div_quo[WIDTH-2:0], 1'b0};
    end
    q_neg     = !uns_r && (a_sign_r ^ b_sign_r);
    r_neg     = !uns_r && a_sign_r;
    quo_final = q_neg ? (-div_quo_next) : div_quo_next;
    rem_final = r_neg ? (-div_rem_next) : div_rem_next;
  end

  // Control state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      hi_lo_write <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      busy        <= busy_next;
      done        <= done_next;
      div_zero    <= div_zero_next;
      hi_lo_write <= hi_lo_write_next;
      hi_out      <= hi_next;
      lo_out      <= lo_next;
    end
  end

  // Next-state and next-output logic. Starts are only looked at in IDLE, so
  // a start during MULT/DIV/FINISH is simply dropped.
  always_comb begin
    state_next       = state;
    count_next       = count;
    busy_next        = 1'b0;
    done_next        = 1'b0;
    div_zero_next    = 1'b0;
    hi_lo_write_next = 1'b0;
    hi_next          = hi_out;
    lo_next          = lo_out;

    case (state)
      IDLE: begin
        if (start_mult) begin
          state_next = MULT;
          count_next = '0;
          busy_next  = 1'b1;
        end else if (start_div) begin
          count_next = '0;
          if (op_b == '0) begin
            state_next    = FINISH;
            done_next     = 1'b1;
            div_zero_next = 1'b1;
          end else begin
            state_next = DIV;
            busy_next  = 1'b1;
          end
        end
      end

      MULT: begin
        if (last_iter) begin
          state_next       = FINISH;
          done_next        = 1'b1;
          hi_lo_write_next = 1'b1;
          hi_next          = product[2*WIDTH-1:WIDTH];
          lo_next          = product[WIDTH-1:0];
        end else begin
          count_next = count + 1'b1;
          busy_next  = 1'b1;
        end
      end

      DIV: begin
        if (last_iter) begin
          state_next       = FINISH;
          done_next        = 1'b1;
          hi_lo_write_next = 1'b1;
          hi_next          = rem_final;
          lo_next          = quo_final;
        end else begin
          count_next = count + 1'b1;
          busy_next  = 1'b1;
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Iteration datapath: operands are captured on the accepting edge and
  // stepped once per edge while in MULT or DIV.
  always_ff @(posedge clk) begin
    if (reset) begin
      uns_r       <= 1'b0;
      a_sign_r    <= 1'b0;
      b_sign_r    <= 1'b0;
      booth_acc   <= '0;
      booth_qm1   <= 1'b0;
      booth_mcand <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_dvs     <= '0;
    end else if (accept_mult) begin
      uns_r       <= uns_in;
      a_sign_r    <= op_a[WIDTH-1];
      b_sign_r    <= op_b[WIDTH-1];
      booth_acc   <= {{(WIDTH+1){1'b0}}, op_b};
      booth_qm1   <= 1'b0;
      booth_mcand <= {(!uns_in && op_a[WIDTH-1]), op_a};
    end else if (accept_div) begin
      uns_r    <= uns_in;
      a_sign_r <= op_a[WIDTH-1];
      b_sign_r <= op_b[WIDTH-1];
      div_rem  <= '0;
      div_quo  <= mag_a;
      div_dvs  <= mag_b;
    end else if (state == MULT) begin
      booth_acc <= booth_next;
      booth_qm1 <= booth_acc[0];
    end else if (state == DIV) begin
      div_rem <= div_rem_next;
      div_quo <= div_quo_next;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// -------------------
// Self-checking bench for muldiv_sequencer (WIDTH = 32). Expected HI/LO and
// flag values are pushed to a queue as each operation is issued and popped
// when the engine reports done.

module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start_mult;
  logic         start_div;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic         hi_lo_write;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
`ifdef MULDIV_UNSIGNED_EN
  logic         is_unsigned;
`endif

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic         hlw;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .op_a        (op_a),
    .op_b        (op_b),
`ifdef MULDIV_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .hi_lo_write (hi_lo_write),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse; returns at the falling edge after the accept edge.
  task automatic apply_stimulus(input logic m, input logic d,
                                input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  // Bounded wait for done, counting cycles seen and busy cycles on the way.
  task automatic wait_done(input int limit, output int lat, output int busy_cycles,
                           output logic seen);
    lat         = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    while (lat < limit && !seen) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy === 1'b1) busy_cycles++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  // Software reference for a signed multiply / divide.
  function automatic exp_t model(input logic is_mult, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      p    = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    e.dz  = 1'b0;
    e.hlw = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dz got %b exp 0", div_zero); end
    checks++; if (hi_lo_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_hlw got %b exp 0", hi_lo_write); end
    checks++; if (hi_out !== '0 || lo_out !== '0) begin errors++; $display("[TB] FAIL reset_hilo got %h:%h exp 0:0", hi_out, lo_out); end
    reset = 1'b0;
  endtask

  task automatic test_op(input string name, input logic m, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    int lat, bc;
    logic seen;
    exp_t e;
    exp_q.push_back(model(m, a, b));
    apply_stimulus(m, !m, a, b);
    wait_done(100, lat, bc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("[TB] FAIL %s_timeout got no done exp done", name); end
    checks++; if (lat !== W) begin errors++; $display("[TB] FAIL %s_latency got %0d exp %0d", name, lat, W); end
    checks++; if (bc !== W) begin errors++; $display("[TB] FAIL %s_busy_cycles got %0d exp %0d", name, bc, W); end
    checks++; if (hi_out !== e.hi) begin errors++; $display("[TB] FAIL %s_hi got %h exp %h", name, hi_out, e.hi); end
    checks++; if (lo_out !== e.lo) begin errors++; $display("[TB] FAIL %s_lo got %h exp %h", name, lo_out, e.lo); end
    checks++; if (div_zero !== e.dz || hi_lo_write !== e.hlw) begin
      errors++; $display("[TB] FAIL %s_flags got dz=%b hlw=%b exp dz=%b hlw=%b", name, div_zero, hi_lo_write, e.dz, e.hlw);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || hi_lo_write !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_pulse got done=%b hlw=%b exp 0 0", name, done, hi_lo_write);
    end
  endtask

  task automatic test_mult_basic();
    exp_t e;
    test_op("mult_7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD);
    e.hi = 32'hFFFF_FFFF;
    e.lo = 32'hFFFF_FFEB;
    checks++; if (hi_out !== e.hi || lo_out !== e.lo) begin
      errors++; $display("[TB] FAIL mult_const got %h:%h exp %h:%h", hi_out, lo_out, e.hi, e.lo);
    end
  endtask

  task automatic test_div_signed();
    test_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2);
    checks++; if (lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin
      errors++; $display("[TB] FAIL div_const got %h:%h exp ffffffff:fffffffd", hi_out, lo_out);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    logic seen;
    exp_t e;
    test_op("mult_3x5", 1'b1, 32'd3, 32'd5);
    e.hi = hi_out; e.lo = lo_out;
    e.hi = 32'd0; e.lo = 32'd15; e.dz = 1'b1; e.hlw = 1'b0;
    exp_q.push_back(e);
    apply_stimulus(1'b0, 1'b1, 32'd9, 32'd0);
    wait_done(100, lat, bc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen || lat !== 0) begin errors++; $display("[TB] FAIL dz_latency got seen=%b lat=%0d exp seen=1 lat=0", seen, lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL dz_busy got %b exp 0", busy); end
    checks++; if (div_zero !== e.dz) begin errors++; $display("[TB] FAIL dz_flag got %b exp %b", div_zero, e.dz); end
    checks++; if (hi_lo_write !== e.hlw) begin errors++; $display("[TB] FAIL dz_hlw got %b exp %b", hi_lo_write, e.hlw); end
    checks++; if (hi_out !== e.hi || lo_out !== e.lo) begin
      errors++; $display("[TB] FAIL dz_hilo got %h:%h exp %h:%h", hi_out, lo_out, e.hi, e.lo);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL dz_pulse got done=%b dz=%b busy=%b exp 0 0 0", done, div_zero, busy);
    end
  endtask

  task automatic test_div_overflow();
    test_op("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++; if (lo_out !== 32'h8000_0000 || hi_out !== 32'd0) begin
      errors++; $display("[TB] FAIL div_ovf_const got %h:%h exp 00000000:80000000", hi_out, lo_out);
    end
  endtask

  task automatic test_both_starts();
    int dones;
    logic [W-1:0] hi_seen, lo_seen;
    exp_t e;
    e.hi = 32'd0; e.lo = 32'd24; e.dz = 1'b0; e.hlw = 1'b1;
    exp_q.push_back(e);
    dones = 0;
    hi_seen = 'x; lo_seen = 'x;
    apply_stimulus(1'b1, 1'b1, 32'd6, 32'd4);
    for (int i = 0; i < 70; i++) begin
      start_div = (i == 9);
      if (i == 9) op_b = 32'd3;
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin hi_seen = hi_out; lo_seen = lo_out; end
      end
      @(negedge clk);
    end
    start_div = 1'b0;
    e = exp_q.pop_front();
    checks++; if (dones !== 1) begin errors++; $display("[TB] FAIL both_done_count got %0d exp 1", dones); end
    checks++; if (hi_seen !== e.hi || lo_seen !== e.lo) begin
      errors++; $display("[TB] FAIL both_result got %h:%h exp %h:%h", hi_seen, lo_seen, e.hi, e.lo);
    end
    checks++; if (lo_out !== e.lo || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL both_after got lo=%h busy=%b exp lo=%h busy=0", lo_out, busy, e.lo);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    apply_stimulus(1'b1, 1'b0, 32'h1234_5678, 32'h10);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (hi_out !== '0 || lo_out !== '0) begin
      errors++; $display("[TB] FAIL rstmid_hilo got %h:%h exp 0:0", hi_out, lo_out);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("[TB] FAIL rstmid_ghost got %0d activity cycles exp 0", dones); end
    test_op("mult_2x3", 1'b1, 32'd2, 32'd3);
    checks++; if (lo_out !== 32'd6) begin errors++; $display("[TB] FAIL rstmid_new got %h exp 6", lo_out); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic seen;
    exp_t e;
    exp_q.push_back(model(1'b1, 32'd5, 32'd5));
    apply_stimulus(1'b1, 1'b0, 32'd5, 32'd5);
    wait_done(100, lat, bc, seen);
    start_mult = 1'b1;
    op_a = 32'd100;
    op_b = 32'd100;
    @(negedge clk);
    start_mult = 1'b0;
    e = exp_q.pop_front();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL finish_start got busy=%b done=%b exp 0 0", busy, done);
    end
    checks++; if (lo_out !== e.lo || hi_out !== e.hi) begin
      errors++; $display("[TB] FAIL finish_hold got %h:%h exp %h:%h", hi_out, lo_out, e.hi, e.lo);
    end
    test_op("mult_-4x-8", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8);
    test_op("div_100/-7", 1'b0, 32'd100, 32'hFFFF_FFF9);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic m;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i < 4) ? $urandom : W'($urandom_range(1, 300));
      if (i[0]) b = -b;
      m = i[1];
      if (!m && b == '0) b = 32'd1;
      test_op(m ? "rand_mult" : "rand_div", m, a, b);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;
`ifdef MULDIV_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    test_reset();
    test_mult_basic();
    test_div_signed();
    test_div_zero();
    test_div_overflow();
    test_both_starts();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
